// File: rtl/mem_port_arbiter_pkg.sv
// mem_arb_pkg: shared types and constants for the unified-memory port arbiter.
package mem_arb_pkg;
   typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_D} state_t;
   typedef enum logic {OWN_IF, OWN_D} owner_t;
   localparam int MEM_ARB_CNT_W = 4;
endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: fetch, data and memory handshake bundle; slave is the arbiter, master is the core/memory side.
interface mem_port_arbiter_if;
   logic if_req, if_gnt, if_valid, if_stall;
   logic [31:0] if_addr, if_rdata;
   logic d_req, d_we, d_gnt, d_valid, d_stall;
   logic [2:0] d_funct3;
   logic [31:0] d_addr, d_wdata, d_rdata;
   logic mem_en, mem_we, mem_ready;
   logic [2:0] mem_funct3;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   modport slave (
      input if_req, if_addr, d_req, d_we, d_addr, d_funct3, d_wdata, mem_ready, mem_rdata,
      output if_gnt, if_valid, if_rdata, if_stall, d_gnt, d_valid, d_rdata, d_stall,
      output mem_en, mem_we, mem_addr, mem_funct3, mem_wdata
   );
   modport master (
      output if_req, if_addr, d_req, d_we, d_addr, d_funct3, d_wdata, mem_ready, mem_rdata,
      input if_gnt, if_valid, if_rdata, if_stall, d_gnt, d_valid, d_rdata, d_stall,
      input mem_en, mem_we, mem_addr, mem_funct3, mem_wdata
   );
endinterface

// File: rtl/mem_port_arbiter_starve_ctr.sv
// mem_arb_starve_ctr: counts data grants issued while fetch waits; force_if asks the arbiter to serve fetch next.
module mem_arb_starve_ctr
   import mem_arb_pkg::*;
#(parameter int STARVE_MAX = 4)
(
   input logic clk,
   input logic reset,
   input logic if_req,
   input logic if_issue,
   input logic d_issue,
   output logic force_if
);
   logic [MEM_ARB_CNT_W-1:0] cnt;
   assign force_if = cnt == MEM_ARB_CNT_W'(STARVE_MAX);
   always_ff @(posedge clk)
      if (reset || if_issue || !if_req) cnt <= '0;
      else if (d_issue && !force_if) cnt <= cnt + 1'b1;
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between fetch and data, data first.
// Define MEM_ARB_FAIRNESS_EN to force a fetch grant after STARVE_MAX consecutive data grants.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(parameter int STARVE_MAX = 4)
(
   input logic clk,
   input logic reset,
   mem_port_arbiter_if.slave bus
);
   state_t state;
   owner_t win;
   logic force_if, if_ok, d_ok, free, pick_d, pick_if, issue, done_if, done_d;
   if (STARVE_MAX < 1 || STARVE_MAX > 15) begin : g_chk
      $error("STARVE_MAX must be in 1..15");
   end
`ifdef MEM_ARB_FAIRNESS_EN
   mem_arb_starve_ctr #(.STARVE_MAX(STARVE_MAX)) u_starve (
      .clk(clk),
      .reset(reset),
      .if_req(bus.if_req),
      .if_issue(free && pick_if),
      .d_issue(free && pick_d),
      .force_if(force_if)
   );
`else
   assign force_if = 1'b0;
`endif
   // A request is still high during its own grant pulse; it must not win again.
   assign if_ok = bus.if_req && !bus.if_gnt;
   assign d_ok = bus.d_req && !bus.d_gnt;
   assign done_if = state == BUSY_IF && bus.mem_ready;
   assign done_d = state == BUSY_D && bus.mem_ready;
   assign free = state == IDLE || done_if || done_d;
   assign pick_d = d_ok && !(force_if && if_ok);
   assign pick_if = if_ok && !pick_d;
   assign issue = free && (pick_d || pick_if);
   assign win = pick_d ? OWN_D : OWN_IF;
   assign bus.if_stall = bus.if_req && !done_if;
   assign bus.d_stall = bus.d_req && !done_d;
   always_ff @(posedge clk)
      if (reset) begin
         state <= IDLE;
         {bus.if_gnt, bus.if_valid, bus.d_gnt, bus.d_valid, bus.mem_en, bus.mem_we} <= '0;
         bus.mem_addr <= '0;
         bus.mem_funct3 <= '0;
         bus.mem_wdata <= '0;
         bus.if_rdata <= '0;
         bus.d_rdata <= '0;
      end else begin
         bus.if_gnt <= free && pick_if;
         bus.d_gnt <= free && pick_d;
         bus.mem_en <= issue;
         bus.if_valid <= done_if;
         bus.d_valid <= done_d;
         if (done_if) bus.if_rdata <= bus.mem_rdata;
         if (done_d) bus.d_rdata <= bus.mem_we ? '0 : bus.mem_rdata;
         if (free) state <= !issue ? IDLE : win == OWN_D ? BUSY_D : BUSY_IF;
         if (issue) begin
            bus.mem_we <= win == OWN_D && bus.d_we;
            bus.mem_addr <= win == OWN_D ? bus.d_addr : bus.if_addr;
            bus.mem_funct3 <= win == OWN_D ? bus.d_funct3 : 3'b010;
            bus.mem_wdata <= win == OWN_D ? bus.d_wdata : '0;
         end
      end
endmodule
